traductor_multi: RTL and testbench

TRADUCTOR_MULTI -- requirements
Module: traductor_multi

---
 rtl/traductor_multi.sv | 155 +++++++++++++++
 tb/tb_traductor_multi.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/traductor_multi.sv
// Code translator: one-hot decoder or DIGITS-deep digit accumulator, selected per burst by mode.
// Optional macro TRADUCTOR_BCD_CHECK_EN rejects accumulate codes above 9 and pulses err.
module traductor_multi #(
  parameter int IN_W   = 4,
  parameter int DIGITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_W-1:0]              in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         mode,
  input  logic                         clr,
  input  logic                         out_ack,
  output logic [2**IN_W-1:0]           dec_out,
  output logic                         dec_valid,
  output logic [IN_W*DIGITS-1:0]       acc_out,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         out_valid,
  output logic                         err
);

  localparam int DEC_W = 2**IN_W;
  localparam int ACC_W = IN_W*DIGITS;
  localparam int CNT_W = $clog2(DIGITS+1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_reg;
  logic               mode_reg;
  logic [DEC_W-1:0]   dec_reg;
  logic               dec_valid_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [CNT_W-1:0]   count_reg;

  logic               xfer;
  logic               mode_eff;
  logic               acc_xfer;
  logic               dec_xfer;
  logic               code_bad;
  logic               digit_take;
  logic               last_digit;
  logic [DEC_W-1:0]   dec_next;
  logic [ACC_W-1:0]   acc_shift;
  logic [CNT_W-1:0]   count_inc;

  // clr blocks the handshake in the same cycle so a coincident code is never half-taken
  assign in_ready = ~clr & (state_reg != FULL);
  assign xfer     = in_valid & in_ready;

  // While EMPTY the live mode pin decides; once a burst starts the latched mode rules
  assign mode_eff = (state_reg == EMPTY) ? mode : mode_reg;
  assign acc_xfer = xfer & mode_eff;
  assign dec_xfer = xfer & ~mode_eff;

`ifdef TRADUCTOR_BCD_CHECK_EN
  assign code_bad = (in > IN_W'(9));
`else
  assign code_bad = 1'b0;
`endif

  assign digit_take = acc_xfer & ~code_bad;
  assign count_inc  = count_reg + 1'b1;
  assign last_digit = (count_inc == CNT_W'(DIGITS));

  generate
    for (genvar gi = 0; gi < DEC_W; gi++) begin : g_dec
      assign dec_next[gi] = (in == IN_W'(gi));
    end
  endgenerate

  // Newest digit enters at the bottom, older digits move up one slot
  assign acc_shift[IN_W-1:0] = in;
  generate
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_shift
      assign acc_shift[gi*IN_W +: IN_W] = acc_reg[(gi-1)*IN_W +: IN_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= EMPTY;
      mode_reg      <= 1'b0;
      dec_reg       <= '0;
      dec_valid_reg <= 1'b0;
      acc_reg       <= '0;
      count_reg     <= '0;
    end else begin
      dec_valid_reg <= 1'b0;
      if (dec_xfer) begin
        dec_reg       <= dec_next;
        dec_valid_reg <= 1'b1;
      end

      if (state_reg == EMPTY) begin
        mode_reg <= mode;
      end

      if (clr) begin
        acc_reg   <= '0;
        count_reg <= '0;
        state_reg <= EMPTY;
      end else begin
        case (state_reg)
          EMPTY, FILL: begin
            if (digit_take) begin
              acc_reg   <= acc_shift;
              count_reg <= count_inc;
              state_reg <= last_digit ? FULL : FILL;
            end
          end
          FULL: begin
            if (out_ack) begin
              acc_reg   <= '0;
              count_reg <= '0;
              state_reg <= EMPTY;
            end
          end
          default: begin
            acc_reg   <= '0;
            count_reg <= '0;
            state_reg <= EMPTY;
          end
        endcase
      end
    end
  end

`ifdef TRADUCTOR_BCD_CHECK_EN
  logic err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= acc_xfer & code_bad;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign dec_out   = dec_reg;
  assign dec_valid = dec_valid_reg;
  assign acc_out   = acc_reg;
  assign count     = count_reg;
  assign out_valid = (state_reg == FULL);

endmodule

// File: tb/tb_traductor_multi.sv
// Bench for traductor_multi: directed scenarios plus random traffic against a queue-based model.
module tb_traductor_multi;

  localparam int IN_W   = 4;
  localparam int DIGITS = 4;
  localparam int DEC_W  = 2**IN_W;
  localparam int ACC_W  = IN_W*DIGITS;
  localparam int CNT_W  = $clog2(DIGITS+1);

`ifdef TRADUCTOR_BCD_CHECK_EN
  localparam bit BCD = 1'b1;
`else
  localparam bit BCD = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [IN_W-1:0]    in;
  logic               in_valid;
  logic               in_ready;
  logic               mode;
  logic               clr;
  logic               out_ack;
  logic [DEC_W-1:0]   dec_out;
  logic               dec_valid;
  logic [ACC_W-1:0]   acc_out;
  logic [CNT_W-1:0]   count;
  logic               out_valid;
  logic               err;

  traductor_multi #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .clr(clr), .out_ack(out_ack), .dec_out(dec_out),
    .dec_valid(dec_valid), .acc_out(acc_out), .count(count),
    .out_valid(out_valid), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the held digits are simply a queue, oldest first
  int               q[$];
  bit               mq = 1'b0;
  logic [DEC_W-1:0] dec_e = '0;
  bit               decv_e = 1'b0;
  bit               err_e = 1'b0;

  function automatic logic [ACC_W-1:0] acc_model();
    logic [ACC_W-1:0] r;
    r = '0;
    foreach (q[i]) r = (r << IN_W) | ACC_W'(q[i]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("dec_out",   64'(dec_out),   64'(dec_e));
    chk("dec_valid", 64'(dec_valid), 64'(decv_e));
    chk("acc_out",   64'(acc_out),   64'(acc_model()));
    chk("count",     64'(count),     64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() == DIGITS));
    chk("err",       64'(err),       64'(err_e));
  endtask

  task automatic model_reset();
    q.delete();
    mq     = 1'b0;
    dec_e  = '0;
    decv_e = 1'b0;
    err_e  = 1'b0;
  endtask

  // Drive one cycle of inputs, check the DUT, then advance the model across the edge
  task automatic step(input bit iv, input int code, input bit md, input bit c, input bit ack);
    bit rdy, xfer, eff;
    int sz;
    in_valid = iv;
    in       = IN_W'(code);
    mode     = md;
    clr      = c;
    out_ack  = ack;
    #1;
    sz  = q.size();
    rdy = !c && (sz < DIGITS);
    chk("in_ready", 64'(in_ready), 64'(rdy));
    check_state();
    xfer   = iv && rdy;
    eff    = (sz == 0) ? md : mq;
    decv_e = 1'b0;
    err_e  = 1'b0;
    if (sz == 0) mq = md;
    if (c) begin
      q.delete();
    end else if (sz == DIGITS) begin
      if (ack) q.delete();
    end else if (xfer) begin
      if (!eff) begin
        dec_e  = DEC_W'(1) << code;
        decv_e = 1'b1;
      end else if (BCD && code > 9) begin
        err_e = 1'b1;
      end else begin
        q.push_back(code);
      end
    end
    if (xfer || c || (ack && sz == DIGITS))
      $display("t=%0t in=%0h mode=%0b clr=%0b ack=%0b xfer=%0b held=%0d", $time, code, md, c, ack, xfer, q.size());
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in = '0; in_valid = 1'b0; mode = 1'b0; clr = 1'b0; out_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;

    // One-hot decode
    step(1, 2, 0, 0, 0);
    chk("dec_0010", 64'(dec_out), 64'h0004);
    chk("dec_pulse", 64'(dec_valid), 64'd1);
    step(0, 0, 0, 0, 0);
    chk("dec_pulse_end", 64'(dec_valid), 64'd0);
    chk("dec_hold", 64'(dec_out), 64'h0004);

    // Fill to full, refuse a fifth code, release with out_ack
    step(0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) step(1, i, 1, 0, 0);
    chk("fill_acc", 64'(acc_out), 64'h1234);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_valid", 64'(out_valid), 64'd1);
    step(1, 5, 1, 0, 0);
    chk("full_hold", 64'(acc_out), 64'h1234);
    step(0, 0, 1, 0, 1);
    chk("ack_acc", 64'(acc_out), 64'h0);
    chk("ack_count", 64'(count), 64'd0);
    chk("ack_ready", 64'(in_ready), 64'd1);

    // clr wins over a coincident code
    step(1, 7, 1, 0, 0);
    step(1, 8, 1, 0, 0);
    step(1, 9, 1, 1, 0);
    chk("clr_acc", 64'(acc_out), 64'h0);
    chk("clr_count", 64'(count), 64'd0);
    step(1, 5, 1, 0, 0);
    chk("after_clr", 64'(acc_out), 64'h0005);
    step(0, 0, 1, 1, 0);

    // Mode is latched once a burst has started
    step(1, 3, 1, 0, 0);
    step(1, 6, 0, 0, 0);
    chk("lock_acc", 64'(acc_out), 64'h0036);
    chk("lock_dec", 64'(dec_valid), 64'd0);
    step(0, 0, 0, 1, 0);

    // Asynchronous reset mid-fill
    step(0, 0, 1, 0, 0);
    step(1, 9, 1, 0, 0);
    chk("pre_rst_acc", 64'(acc_out), 64'h0009);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_state();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, 4, 1, 0, 0);
    chk("post_rst_acc", 64'(acc_out), 64'h0004);
    step(0, 0, 1, 1, 0);

    // Code above 9 in accumulate mode
    step(1, 'hA, 1, 0, 0);
`ifdef TRADUCTOR_BCD_CHECK_EN
    chk("bcd_err", 64'(err), 64'd1);
    chk("bcd_count", 64'(count), 64'd0);
    step(0, 0, 1, 0, 0);
    chk("bcd_err_end", 64'(err), 64'd0);
`else
    chk("nobcd_acc", 64'(acc_out), 64'h000A);
    chk("nobcd_err", 64'(err), 64'd0);
`endif
    step(0, 0, 1, 1, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 2) == 0);
    end
    check_state();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
